sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO built on an inferred RAM, with no vendor macro.
- Replaces the dual-clock macro wrapper wherever producer and consumer share one clock.
- Adds run-time-independent generics: width, depth, almost thresholds, FWFT or standard read mode.
- Adds a synchronous flush and a single occupancy count.
- Protection against write-when-full and read-when-empty is built in, with one-cycle error pulses.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sdp_ram.sv | 40 ++++
 rtl/sync_fifo_param.sv | 137 +++++++++++++
 tb/tb_sync_fifo_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Ceiling log2, usable where $clog2 is unavailable; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output that holds its value when rd_en is low.
module sdp_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned DEPTH      = 2048,
  localparam int unsigned AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Only the output register is reset; array contents are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO around an inferred RAM: control, occupancy
// count, registered-count flags, error pulses and an optional FWFT stage.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 9,
  parameter int unsigned DEPTH               = 2048,
  parameter int unsigned ALMOST_EMPTY_OFFSET = 128,
  parameter int unsigned ALMOST_FULL_OFFSET  = 128,
  parameter int unsigned FWFT                = FIFO_FWFT,
  localparam int unsigned CNT_W              = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] dI,
  input  logic                  wrEn,
  input  logic                  rdEn,
  output logic [DATA_WIDTH-1:0] dO,
  output logic                  empty,
  output logic                  full,
  output logic                  almostEmpty,
  output logic                  almostFull,
  output logic [CNT_W-1:0]      count,
  output logic                  wrErr,
  output logic                  rdErr
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam bit IS_FWFT = (FWFT == FIFO_FWFT);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - ALMOST_FULL_OFFSET);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(ALMOST_EMPTY_OFFSET);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if ((ALMOST_EMPTY_OFFSET >= DEPTH) || (ALMOST_FULL_OFFSET >= DEPTH)) begin : g_bad_offset
    $error("sync_fifo_param: almost offsets must be smaller than DEPTH");
  end
  if ((DATA_WIDTH < 1) || (DATA_WIDTH > 72)) begin : g_bad_width
    $error("sync_fifo_param: DATA_WIDTH must be within 1..72");
  end
  if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be FIFO_STD or FIFO_FWFT");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             wr_err_q, wr_err_d;
  logic             rd_err_q, rd_err_d;

  logic             full_w, empty_w;
  logic             wr_acc, rd_acc, ram_rd_en;
  logic [CNT_W-1:0] ram_cnt;

  assign full_w  = (count_q == FULL_LVL);
  assign empty_w = IS_FWFT ? ~out_valid_q : (count_q == '0);

  always_comb begin
    wr_acc = wrEn & ~full_w & ~flush;
    rd_acc = rdEn & ~empty_w & ~flush;

    // In FWFT mode count includes the staged head word, so the RAM holds one
    // fewer; in standard mode out_valid_q stays 0 and the two are equal.
    ram_cnt = count_q - CNT_W'(out_valid_q);
    if (IS_FWFT) ram_rd_en = ~flush & (ram_cnt != '0) & (~out_valid_q | rd_acc);
    else         ram_rd_en = rd_acc;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_acc)    wr_ptr_d = wr_ptr_q + AW'(1);
      if (ram_rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc)      count_d = count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
      if (!IS_FWFT)       out_valid_d = 1'b0;
      else if (ram_rd_en) out_valid_d = 1'b1;
      else if (rd_acc)    out_valid_d = 1'b0;
    end

    wr_err_d = wrEn & full_w & ~flush;
    rd_err_d = rdEn & empty_w & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      wr_err_q    <= wr_err_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // The RAM read register doubles as dO: the FWFT head stage or the standard read latch.
  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_q),
    .wr_data(dI),
    .rd_en  (ram_rd_en),
    .rd_addr(rd_ptr_q),
    .rd_data(dO)
  );

  assign empty       = empty_w;
  assign full        = full_w;
  assign almostEmpty = (count_q <= AE_LVL);
  assign almostFull  = (count_q >= AF_LVL);
  assign count       = count_q;
  assign wrErr       = wr_err_q;
  assign rdErr       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: FWFT and standard instances on
// shared stimulus, a queue scoreboard and a per-cycle reference of flags.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int unsigned DW  = 9;
  localparam int unsigned DEP = 16;
  localparam int unsigned OFS = 4;
  localparam int unsigned CW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush, wr_en, rd_en;
  logic [DW-1:0] d_in;

  logic [DW-1:0] f_do, s_do, o_do;
  logic [CW-1:0] f_count, s_count, o_count;
  logic f_empty, f_full, f_aempty, f_afull, f_wr_err, f_rd_err;
  logic s_empty, s_full, s_aempty, s_afull, s_wr_err, s_rd_err;
  logic o_empty, o_full, o_aempty, o_afull, o_wr_err, o_rd_err;

  bit            mode_fwft;
  logic [DW-1:0] sb_q[$];
  bit            mv;
  logic [DW-1:0] exp_do;
  int unsigned   n_cmp, n_err;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_EMPTY_OFFSET(OFS),
    .ALMOST_FULL_OFFSET(OFS), .FWFT(FIFO_FWFT)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .dI(d_in), .wrEn(wr_en), .rdEn(rd_en),
    .dO(f_do), .empty(f_empty), .full(f_full), .almostEmpty(f_aempty),
    .almostFull(f_afull), .count(f_count), .wrErr(f_wr_err), .rdErr(f_rd_err)
  );

  sync_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_EMPTY_OFFSET(OFS),
    .ALMOST_FULL_OFFSET(OFS), .FWFT(FIFO_STD)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush), .dI(d_in), .wrEn(wr_en), .rdEn(rd_en),
    .dO(s_do), .empty(s_empty), .full(s_full), .almostEmpty(s_aempty),
    .almostFull(s_afull), .count(s_count), .wrErr(s_wr_err), .rdErr(s_rd_err)
  );

  always_comb begin
    o_do     = mode_fwft ? f_do     : s_do;
    o_count  = mode_fwft ? f_count  : s_count;
    o_empty  = mode_fwft ? f_empty  : s_empty;
    o_full   = mode_fwft ? f_full   : s_full;
    o_aempty = mode_fwft ? f_aempty : s_aempty;
    o_afull  = mode_fwft ? f_afull  : s_afull;
    o_wr_err = mode_fwft ? f_wr_err : s_wr_err;
    o_rd_err = mode_fwft ? f_rd_err : s_rd_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ctx, input bit exp_werr, input bit exp_rerr);
    int unsigned n;
    bit exp_empty;
    n = sb_q.size();
    exp_empty = mode_fwft ? !mv : (n == 0);
    check_eq({ctx, "_count"},  32'(o_count),  32'(n));
    check_eq({ctx, "_empty"},  32'(o_empty),  32'(exp_empty));
    check_eq({ctx, "_full"},   32'(o_full),   32'(n == DEP));
    check_eq({ctx, "_afull"},  32'(o_afull),  32'(n >= DEP - OFS));
    check_eq({ctx, "_aempty"}, 32'(o_aempty), 32'(n <= OFS));
    check_eq({ctx, "_wrerr"},  32'(o_wr_err), 32'(exp_werr));
    check_eq({ctx, "_rderr"},  32'(o_rd_err), 32'(exp_rerr));
    check_eq({ctx, "_do"},     32'(o_do),     32'(exp_do));
  endtask

  // Asserted between clock edges; outputs must clear without any edge.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    mv     = 1'b0;
    exp_do = '0;
    check_outputs("rst", 1'b0, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; d_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    int unsigned   n;
    bit            full_m, empty_m, wacc, racc, werr, rerr, load;
    logic [DW-1:0] popped;
    n       = sb_q.size();
    full_m  = (n == DEP);
    empty_m = mode_fwft ? !mv : (n == 0);
    wacc    = w && !full_m && !f;
    racc    = r && !empty_m && !f;
    werr    = w && full_m && !f;
    rerr    = r && empty_m && !f;
    load    = mode_fwft && !f && ((int'(n) - int'(mv)) > 0) && (!mv || racc);
    wr_en = w; rd_en = r; flush = f; d_in = d;
    if (mode_fwft && racc) check_eq("pop_data", 32'(o_do), 32'(sb_q[0]));
    @(posedge clk); #1;
    if (f) begin
      sb_q.delete();
      mv = 1'b0;
    end else begin
      if (racc) begin
        popped = sb_q.pop_front();
        if (!mode_fwft) exp_do = popped;
      end
      if (wacc) sb_q.push_back(d);
      if (mode_fwft) mv = load ? 1'b1 : (racc ? 1'b0 : mv);
    end
    if (mode_fwft && mv) exp_do = sb_q[0];
    check_outputs("cyc", werr, rerr);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    mode_fwft = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; d_in = '0;
    mv = 1'b0; exp_do = '0;
    #7;
    apply_reset();
    repeat (20) step(1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
    check_eq("fill_full", 32'(o_full), 32'd1);
    step(1'b1, 1'b0, 1'b0, 9'h0AA);
    check_eq("ovf_wrerr", 32'(o_wr_err), 32'd1);
    check_eq("ovf_count", 32'(o_count), 32'd16);
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, '0);
    check_eq("drain_empty", 32'(o_empty), 32'd1);
    step(1'b0, 1'b1, 1'b0, '0);

    step(1'b1, 1'b0, 1'b0, 9'h1A5);
    check_eq("fwft_lat_k_empty", 32'(o_empty), 32'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    check_eq("fwft_lat_do", 32'(o_do), 32'h1A5);
    check_eq("fwft_lat_empty", 32'(o_empty), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, DW'(9'h040 + i));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, DW'(9'h100 + i));
    check_eq("simul_count", 32'(o_count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 9'h077);
    check_eq("empty_wr_rd_count", 32'(o_count), 32'd1);
    check_eq("empty_wr_rd_rderr", 32'(o_rd_err), 32'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, DW'(9'h080 + i));
    step(1'b1, 1'b0, 1'b1, 9'h1FF);
    check_eq("flush_count", 32'(o_count), 32'd0);
    check_eq("flush_empty", 32'(o_empty), 32'd1);
    check_eq("flush_wrerr", 32'(o_wr_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b0, DW'(9'h0C0 + i));
    apply_reset();
    step(1'b0, 1'b0, 1'b0, '0);

    mode_fwft = 1'b0;
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 9'h1A5);
    check_eq("std_lat_empty", 32'(o_empty), 32'd0);
    check_eq("std_lat_hold", 32'(o_do), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("std_lat_do", 32'(o_do), 32'h1A5);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'(9'h150 + i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
